// File: rtl/multi_task_sequencer_pkg.sv
// Shared types for the multi-task sequencer: FSM state encoding and the report record.
// Report field widths match the sequencer's default parameters; the top casts into and out of them.
package multi_task_seq_pkg;

    localparam int MTS_TASK_ID_W  = 4;
    localparam int MTS_BYTE_CNT_W = 32;
    localparam int MTS_LAT_W      = 32;

    typedef enum logic [2:0] {
        MTS_IDLE,
        MTS_SELECT,
        MTS_LAUNCH,
        MTS_RUN,
        MTS_REPORT,
        MTS_DONE
    } mts_state_e;

    typedef struct packed {
        logic [MTS_TASK_ID_W-1:0]  task_number;
        logic [MTS_BYTE_CNT_W-1:0] num_bytes_out;
        logic [MTS_LAT_W-1:0]      latency;
        logic                      timeout;
    } mts_report_t;

endpackage

// File: rtl/multi_task_sequencer_pick_lowest.sv
// Combinational lowest-set-bit encoder used to choose the next task from the remaining mask.
module mts_pick_lowest #(
    parameter  int NUM_TASKS = 16,
    localparam int TASK_ID_W = $clog2(NUM_TASKS)
) (
    input  logic [NUM_TASKS-1:0] mask,
    output logic [TASK_ID_W-1:0] idx,
    output logic                 any
);

    // Scan from the top down so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx = '0;
        any = |mask;
        for (int i = NUM_TASKS - 1; i >= 0; i--) begin
            if (mask[i]) idx = TASK_ID_W'(i);
        end
    end

endmodule

// File: rtl/multi_task_sequencer.sv
// Runs one task per set bit of a snapshot mask, lowest index first, and emits a latency report per task.
// Optional watchdog: define MTS_TIMEOUT_EN to abort a task after TIMEOUT_CYCLES in RUN.
module multi_task_sequencer
    import multi_task_seq_pkg::*;
#(
    parameter  int NUM_TASKS      = 16,
    parameter  int BYTE_CNT_W     = 32,
    parameter  int LAT_W          = 32,
    parameter  int TIMEOUT_CYCLES = 1_000_000,
    localparam int TASK_ID_W      = $clog2(NUM_TASKS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_tests,
    input  logic [NUM_TASKS-1:0]  enabled_tasks,
    input  logic [BYTE_CNT_W-1:0] num_bytes_in_to_task,
    output logic                  task_start,
    output logic [TASK_ID_W-1:0]  task_number,
    output logic [BYTE_CNT_W-1:0] task_num_bytes_in,
    input  logic                  task_done,
    input  logic [BYTE_CNT_W-1:0] task_num_bytes_out,
    output logic                  rpt_valid,
    input  logic                  rpt_ready,
    output logic [TASK_ID_W-1:0]  rpt_task_number,
    output logic [BYTE_CNT_W-1:0] rpt_num_bytes_out,
    output logic [LAT_W-1:0]      rpt_latency,
    output logic                  rpt_timeout,
    output logic                  busy,
    output logic                  tasks_done
);

`ifdef MTS_TIMEOUT_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

    mts_state_e             state;
    logic [NUM_TASKS-1:0]   remaining;
    logic [LAT_W-1:0]       lat_cnt;
    logic [LAT_W-1:0]       lat_next;
    logic                   timeout_hit;
    mts_report_t            rpt_q;
    logic [TASK_ID_W-1:0]   pick_idx;
    logic                   pick_any;

    mts_pick_lowest #(.NUM_TASKS(NUM_TASKS)) u_pick (
        .mask (remaining),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // lat_next is the latency a task_done in the current RUN cycle would report.
    assign lat_next    = sat_inc(lat_cnt);
    assign timeout_hit = WDOG_EN && (lat_next == LAT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= MTS_IDLE;
            remaining         <= '0;
            lat_cnt           <= '0;
            rpt_q             <= '0;
            task_start        <= 1'b0;
            task_number       <= '0;
            task_num_bytes_in <= '0;
            rpt_valid         <= 1'b0;
            busy              <= 1'b0;
            tasks_done        <= 1'b0;
        end else begin
            task_start <= 1'b0;
            case (state)
                MTS_IDLE, MTS_DONE: begin
                    if (start_tests) begin
                        remaining         <= enabled_tasks;
                        task_num_bytes_in <= num_bytes_in_to_task;
                        busy              <= 1'b1;
                        tasks_done        <= 1'b0;
                        state             <= MTS_SELECT;
                    end
                end
                MTS_SELECT: begin
                    if (!pick_any) begin
                        busy       <= 1'b0;
                        tasks_done <= 1'b1;
                        state      <= MTS_DONE;
                    end else begin
                        remaining[pick_idx] <= 1'b0;
                        task_number         <= pick_idx;
                        task_start          <= 1'b1;
                        state               <= MTS_LAUNCH;
                    end
                end
                MTS_LAUNCH: begin
                    lat_cnt <= '0;
                    state   <= MTS_RUN;
                end
                MTS_RUN: begin
                    if (task_done) begin
                        rpt_q.task_number   <= MTS_TASK_ID_W'(task_number);
                        rpt_q.num_bytes_out <= MTS_BYTE_CNT_W'(task_num_bytes_out);
                        rpt_q.latency       <= MTS_LAT_W'(lat_next);
                        rpt_q.timeout       <= 1'b0;
                        rpt_valid           <= 1'b1;
                        state               <= MTS_REPORT;
                    end else if (timeout_hit) begin
                        rpt_q.task_number   <= MTS_TASK_ID_W'(task_number);
                        rpt_q.num_bytes_out <= '0;
                        rpt_q.latency       <= MTS_LAT_W'(lat_next);
                        rpt_q.timeout       <= 1'b1;
                        rpt_valid           <= 1'b1;
                        state               <= MTS_REPORT;
                    end else begin
                        lat_cnt <= lat_next;
                    end
                end
                MTS_REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        state     <= MTS_SELECT;
                    end
                end
                default: state <= MTS_IDLE;
            endcase
        end
    end

    // Without the watchdog, rpt_q.timeout is only ever loaded with 0.
    assign rpt_task_number   = TASK_ID_W'(rpt_q.task_number);
    assign rpt_num_bytes_out = BYTE_CNT_W'(rpt_q.num_bytes_out);
    assign rpt_latency       = LAT_W'(rpt_q.latency);
    assign rpt_timeout       = rpt_q.timeout;

endmodule

// File: tb/tb_multi_task_sequencer.sv
// Randomized self-checking bench for multi_task_sequencer; acts as task responder and report consumer.
// Define MTS_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES = 100.
module tb_multi_task_sequencer;

    localparam int NT = 16;
    localparam int BW = 32;
    localparam int LW = 32;
`ifdef MTS_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 1_000_000;
`endif

    logic          clk;
    logic          reset_n;
    logic          start_tests;
    logic [NT-1:0] enabled_tasks;
    logic [BW-1:0] num_bytes_in_to_task;
    logic          task_start;
    logic [3:0]    task_number;
    logic [BW-1:0] task_num_bytes_in;
    logic          task_done;
    logic [BW-1:0] task_num_bytes_out;
    logic          rpt_valid;
    logic          rpt_ready;
    logic [3:0]    rpt_task_number;
    logic [BW-1:0] rpt_num_bytes_out;
    logic [LW-1:0] rpt_latency;
    logic          rpt_timeout;
    logic          busy;
    logic          tasks_done;

    multi_task_sequencer #(
        .NUM_TASKS(NT), .BYTE_CNT_W(BW), .LAT_W(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .start_tests          (start_tests),
        .enabled_tasks        (enabled_tasks),
        .num_bytes_in_to_task (num_bytes_in_to_task),
        .task_start           (task_start),
        .task_number          (task_number),
        .task_num_bytes_in    (task_num_bytes_in),
        .task_done            (task_done),
        .task_num_bytes_out   (task_num_bytes_out),
        .rpt_valid            (rpt_valid),
        .rpt_ready            (rpt_ready),
        .rpt_task_number      (rpt_task_number),
        .rpt_num_bytes_out    (rpt_num_bytes_out),
        .rpt_latency          (rpt_latency),
        .rpt_timeout          (rpt_timeout),
        .busy                 (busy),
        .tasks_done           (tasks_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] bytes;
        int          lat;
        bit          to;
    } rec_t;

    // One batch: expected order is the ascending list of set bits; each launched task
    // completes after a chosen delay (cycles after task_start) which is its expected latency.
    task automatic run_batch(input logic [15:0] mask, input logic [31:0] bin,
                             input int fix_dly, input bit fix_b, input logic [31:0] fix_bytes,
                             input int hold_first, input bit poke_start, input int hang_idx);
        int          order[$];
        rec_t        exp_q[$];
        rec_t        r;
        int          launches, xfers, cd, hold, d, cyc, idx;
        bit          done_seen, poked;
        logic [31:0] pend_bytes, b;
        launches = 0; xfers = 0; cd = 0; hold = hold_first;
        done_seen = 0; poked = 0; pend_bytes = '0;
        for (int i = 0; i < NT; i++) if (mask[i]) order.push_back(i);

        @(negedge clk);
        start_tests = 1'b1; enabled_tasks = mask; num_bytes_in_to_task = bin; rpt_ready = 1'b0;
        @(negedge clk);
        start_tests = 1'b0;
        enabled_tasks = NT'($urandom);
        num_bytes_in_to_task = $urandom;
        check_eq("busy_after_start", busy, 1);
        check_eq("tasks_done_after_start", tasks_done, 0);

        for (cyc = 1; cyc < 4000 && !done_seen; cyc++) begin
            if (cyc > 1) @(negedge clk);
            start_tests = 1'b0;
            task_done = 1'b0;
            task_num_bytes_out = $urandom;
            if (tasks_done) begin
                done_seen = 1;
                if (order.size() == 0) check_eq("empty_done_cycle", cyc, 2);
            end else begin
                if (task_start) begin
                    check_eq("start_while_rpt_pending", exp_q.size(), 0);
                    if (launches >= order.size()) begin
                        check_eq("extra_task_start", launches, order.size() - 1);
                    end else begin
                        idx = order[launches];
                        check_eq("task_number", task_number, idx);
                        check_eq("task_num_bytes_in", task_num_bytes_in, bin);
                        d = (fix_dly > 0) ? fix_dly : $urandom_range(1, 12);
                        b = fix_b ? fix_bytes : $urandom;
                        if (idx == hang_idx) begin
                            cd = 0;
                            exp_q.push_back('{idx, 32'd0, TO, 1'b1});
                        end else begin
                            cd = d;
                            pend_bytes = b;
                            exp_q.push_back('{idx, b, d, 1'b0});
                        end
                    end
                    launches++;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        task_done = 1'b1;
                        task_num_bytes_out = pend_bytes;
                    end
                    if (poke_start && !poked) begin
                        start_tests = 1'b1;
                        enabled_tasks = '1;
                        poked = 1;
                    end
                end
                if (rpt_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_rpt_valid", rpt_valid, 0);
                    end else begin
                        r = exp_q[0];
                        check_eq("rpt_task_number", rpt_task_number, r.idx);
                        check_eq("rpt_num_bytes_out", rpt_num_bytes_out, r.bytes);
                        check_eq("rpt_latency", rpt_latency, r.lat);
                        check_eq("rpt_timeout", rpt_timeout, r.to);
                        check_eq("task_number_hold", task_number, r.idx);
                        if (hold > 0) begin
                            hold--;
                            rpt_ready = 1'b0;
                        end else begin
                            rpt_ready = 1'($urandom_range(0, 1));
                            if (rpt_ready) begin
                                void'(exp_q.pop_front());
                                xfers++;
                            end
                        end
                    end
                end else begin
                    rpt_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        start_tests = 1'b0;
        task_done = 1'b0;
        check_eq("batch_completed", done_seen, 1);
        check_eq("task_start_count", launches, order.size());
        check_eq("report_count", xfers, order.size());
        check_eq("busy_at_done", busy, 0);
        check_eq("rpt_valid_at_done", rpt_valid, 0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset_n = 1'b0; start_tests = 1'b0; enabled_tasks = '0; num_bytes_in_to_task = '0;
        task_done = 1'b0; task_num_bytes_out = '0; rpt_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_task_start", task_start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tasks_done", tasks_done, 0);
        check_eq("rst_rpt_valid", rpt_valid, 0);
        check_eq("rst_task_number", task_number, 0);
        check_eq("rst_rpt_latency", rpt_latency, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // stray completion while idle must not produce a report or start anything
        task_done = 1'b1; task_num_bytes_out = 32'h1234;
        @(negedge clk);
        task_done = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_stray_rpt_valid", rpt_valid, 0);
        check_eq("idle_stray_busy", busy, 0);
        check_eq("idle_stray_task_start", task_start, 0);

        run_batch(16'h0001, 32'd64, 5, 1'b1, 32'd4, 0, 1'b0, -1);
        run_batch(16'h8421, $urandom, 0, 1'b0, '0, 0, 1'b0, -1);
        run_batch(16'h0000, $urandom, 0, 1'b0, '0, 0, 1'b0, -1);
        run_batch(16'h0006, $urandom, 0, 1'b0, '0, 20, 1'b0, -1);
        run_batch(16'h0013, $urandom, 4, 1'b0, '0, 0, 1'b1, -1);
`ifdef MTS_TIMEOUT_EN
        run_batch(16'h0003, $urandom, 0, 1'b0, '0, 0, 1'b0, 0);
`endif
        for (int k = 0; k < 8; k++) begin
            run_batch(16'($urandom), $urandom, 0, 1'b0, '0, 0, 1'b0, -1);
        end

        // stray completion in DONE
        task_done = 1'b1;
        @(negedge clk);
        task_done = 1'b0;
        @(negedge clk);
        check_eq("done_stray_tasks_done", tasks_done, 1);
        check_eq("done_stray_rpt_valid", rpt_valid, 0);

        // reset in the middle of a batch discards it
        start_tests = 1'b1; enabled_tasks = '1;
        @(negedge clk);
        start_tests = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_task_start", task_start, 0);
        check_eq("midrst_tasks_done", tasks_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_batch(16'h0030, $urandom, 0, 1'b0, '0, 0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
